hash_match_engine: RTL and testbench

- Streaming comparator that checks a sequence of candidate hashes (dictionary digests) against one latched target hash.
- Reports the index of each hit, a found flag, a candidate count and a completion pulse.
- Sits between the hash core output stream and the cracker control logic.
- Parametrised successor of the single-cycle SHA-1 equality compare. Adds digest width, truncated compare, a valid/ready handshake, first-hit/all-hits modes and abort.

---
 rtl/hash_match_engine.sv | 128 ++++++++++++
 tb/tb_hash_match_engine.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_match_engine.sv
// Streaming digest comparator: one latched target vs. a candidate stream; hit pulse 1 cycle after accept.
// Backpressure: cand_ready is high only in RUN without abort; a terminating beat drops ready on the next cycle.
module hash_match_engine #(
  parameter int HASH_W = 160,
  parameter int CMP_W  = 160,
  parameter int IDX_W  = 16,
  parameter int MCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [HASH_W-1:0] target,
  input  logic              first_only,
  input  logic              abort,
  input  logic              cand_valid,
  input  logic [HASH_W-1:0] cand_hash,
  input  logic              cand_last,
  output logic              cand_ready,
  output logic              match_valid,
  output logic [IDX_W-1:0]  match_idx,
  output logic              found,
  output logic [MCNT_W-1:0] match_cnt,
  output logic [IDX_W-1:0]  count,
  output logic              ovf,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [HASH_W-1:0]   target_q, target_d;
  logic                first_only_q, first_only_d;
  logic                match_valid_q, match_valid_d;
  logic [IDX_W-1:0]    match_idx_q, match_idx_d;
  logic                found_q, found_d;
  logic [MCNT_W-1:0]   match_cnt_q, match_cnt_d;
  logic [IDX_W-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d;

  logic accept;
  logic hit;
  logic idx_full;

  // Only the top CMP_W bits take part in the compare (truncated digests).
  assign hit        = (cand_hash[HASH_W-1 -: CMP_W] == target_q[HASH_W-1 -: CMP_W]);
  assign cand_ready = (state_q == S_RUN) && !abort;
  assign accept     = cand_valid && cand_ready;
  assign idx_full   = (count_q == {IDX_W{1'b1}});

  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    first_only_d  = first_only_q;
    match_valid_d = 1'b0;
    match_idx_d   = match_idx_q;
    found_d       = found_q;
    match_cnt_d   = match_cnt_q;
    count_d       = count_q;
    ovf_d         = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          target_d     = target;
          first_only_d = first_only;
          match_idx_d  = '0;
          found_d      = 1'b0;
          match_cnt_d  = '0;
          count_d      = '0;
          ovf_d        = 1'b0;
          state_d      = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_DONE;
        end else if (accept) begin
          match_valid_d = hit;
          if (hit) begin
            match_idx_d = count_q;
            found_d     = 1'b1;
            if (match_cnt_q != {MCNT_W{1'b1}}) match_cnt_d = match_cnt_q + MCNT_W'(1);
          end
          // count wraps to zero naturally when the index space is exhausted
          count_d = count_q + IDX_W'(1);
          if (idx_full) ovf_d = 1'b1;
          if (cand_last || (hit && first_only_q) || idx_full) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      target_q      <= '0;
      first_only_q  <= 1'b0;
      match_valid_q <= 1'b0;
      match_idx_q   <= '0;
      found_q       <= 1'b0;
      match_cnt_q   <= '0;
      count_q       <= '0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      first_only_q  <= first_only_d;
      match_valid_q <= match_valid_d;
      match_idx_q   <= match_idx_d;
      found_q       <= found_d;
      match_cnt_q   <= match_cnt_d;
      count_q       <= count_d;
      ovf_q         <= ovf_d;
    end
  end

  assign match_valid = match_valid_q;
  assign match_idx   = match_idx_q;
  assign found       = found_q;
  assign match_cnt   = match_cnt_q;
  assign count       = count_q;
  assign ovf         = ovf_q;
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_hash_match_engine.sv
// Directed bench: full-width, 32-bit truncated and 3-bit-index instances share one stimulus stream.
module tb_hash_match_engine;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [159:0] target;
  logic         first_only;
  logic         abort;
  logic         cand_valid;
  logic [159:0] cand_hash;
  logic         cand_last;

  logic cand_ready_a, match_valid_a, found_a, ovf_a, busy_a, done_a;
  logic [15:0] match_idx_a, count_a;
  logic [7:0]  match_cnt_a;
  logic cand_ready_b, match_valid_b, found_b, ovf_b, busy_b, done_b;
  logic [15:0] match_idx_b, count_b;
  logic [7:0]  match_cnt_b;
  logic cand_ready_c, match_valid_c, found_c, ovf_c, busy_c, done_c;
  logic [2:0]  match_idx_c, count_c;
  logic [7:0]  match_cnt_c;

  hash_match_engine #(.HASH_W(160), .CMP_W(160), .IDX_W(16), .MCNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .target(target), .first_only(first_only),
    .abort(abort), .cand_valid(cand_valid), .cand_hash(cand_hash), .cand_last(cand_last),
    .cand_ready(cand_ready_a), .match_valid(match_valid_a), .match_idx(match_idx_a),
    .found(found_a), .match_cnt(match_cnt_a), .count(count_a), .ovf(ovf_a),
    .busy(busy_a), .done(done_a));

  hash_match_engine #(.HASH_W(160), .CMP_W(32), .IDX_W(16), .MCNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .target(target), .first_only(first_only),
    .abort(abort), .cand_valid(cand_valid), .cand_hash(cand_hash), .cand_last(cand_last),
    .cand_ready(cand_ready_b), .match_valid(match_valid_b), .match_idx(match_idx_b),
    .found(found_b), .match_cnt(match_cnt_b), .count(count_b), .ovf(ovf_b),
    .busy(busy_b), .done(done_b));

  hash_match_engine #(.HASH_W(160), .CMP_W(160), .IDX_W(3), .MCNT_W(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start), .target(target), .first_only(first_only),
    .abort(abort), .cand_valid(cand_valid), .cand_hash(cand_hash), .cand_last(cand_last),
    .cand_ready(cand_ready_c), .match_valid(match_valid_c), .match_idx(match_idx_c),
    .found(found_c), .match_cnt(match_cnt_c), .count(count_c), .ovf(ovf_c),
    .busy(busy_c), .done(done_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // Pulse monitor for dut_a, sampled on the falling edge.
  logic        clr_mon;
  int          n_mv_a;
  int          n_done_a;
  logic [15:0] idx_seen_a;
  always @(negedge clk) begin
    if (clr_mon) begin
      n_mv_a   <= 0;
      n_done_a <= 0;
      idx_seen_a <= 16'hFFFF;
    end else begin
      if (match_valid_a) begin
        n_mv_a     <= n_mv_a + 1;
        idx_seen_a <= match_idx_a;
      end
      if (done_a) n_done_a <= n_done_a + 1;
    end
  end

  localparam logic [159:0] T  = 160'hDEADBEEF_01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [159:0] T2 = 160'hCAFEF00D_11111111_22222222_33333333_44444444;

  typedef struct {
    logic [159:0] tgt;
    logic [159:0] h;
    logic         hit_a;
    logic         hit_b;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [159:0] t, input logic f);
    clr_mon    = 1'b1;
    start      = 1'b1;
    target     = t;
    first_only = f;
    tick();
    start   = 1'b0;
    clr_mon = 1'b0;
  endtask

  task automatic beat(input logic [159:0] h, input logic last);
    cand_valid = 1'b1;
    cand_hash  = h;
    cand_last  = last;
    tick();
    cand_valid = 1'b0;
    cand_last  = 1'b0;
  endtask

  function automatic logic [159:0] mk(input int k);
    logic [159:0] r;
    r = {32'hA0000000 + 32'(k), 128'h01234567_89ABCDEF_00112233_44556677};
    return r;
  endfunction

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; start = 1'b0; target = '0; first_only = 1'b0; abort = 1'b0;
    cand_valid = 1'b0; cand_hash = '0; cand_last = 1'b0; clr_mon = 1'b1;

    vecs[0] = '{T, T, 1'b1, 1'b1};
    vecs[1] = '{T, T ^ (160'd1 << 0), 1'b0, 1'b1};
    vecs[2] = '{T, T ^ (160'd1 << 127), 1'b0, 1'b1};
    vecs[3] = '{T, T ^ (160'd1 << 128), 1'b0, 1'b0};
    vecs[4] = '{T, T ^ (160'd1 << 159), 1'b0, 1'b0};
    vecs[5] = '{T, ~T, 1'b0, 1'b0};
    vecs[6] = '{160'd0, 160'd0, 1'b1, 1'b1};

    #2;
    chk("rst_ready", cand_ready_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_count", count_a, 0);
    chk("rst_found", found_a, 0);
    #10;
    rst_n = 1'b1;
    tick();

    // Run 1: scan all, hit on beat 3; a beat offered in the start cycle is ignored
    cand_valid = 1'b1; cand_hash = T;
    do_start(T, 1'b0);
    chk("r1_busy", busy_a, 1);
    chk("r1_count_after_start", count_a, 0);
    for (int i = 0; i < 5; i++) beat((i == 3) ? T : mk(i), i == 4);
    chk("r1_done", done_a, 1);
    chk("r1_ready_in_done", cand_ready_a, 0);
    tick();
    chk("r1_done_low", done_a, 0);
    chk("r1_n_mv", n_mv_a, 1);
    chk("r1_idx", idx_seen_a, 3);
    chk("r1_n_done", n_done_a, 1);
    chk("r1_found", found_a, 1);
    chk("r1_mcnt", match_cnt_a, 1);
    chk("r1_count", count_a, 5);
    chk("r1_ovf", ovf_a, 0);

    // Run 2: first-hit mode, beats 1 and 3 match
    do_start(T, 1'b1);
    beat(mk(0), 1'b0);
    beat(T, 1'b0);
    chk("r2_ready_after_hit", cand_ready_a, 0);
    chk("r2_match_valid", match_valid_a, 1);
    cand_valid = 1'b1; cand_hash = mk(2);
    tick();
    chk("r2_ready_idle", cand_ready_a, 0);
    cand_hash = T;
    tick();
    cand_valid = 1'b0;
    chk("r2_idx", match_idx_a, 1);
    chk("r2_count", count_a, 2);
    chk("r2_mcnt", match_cnt_a, 1);
    chk("r2_n_mv", n_mv_a, 1);
    chk("r2_n_done", n_done_a, 1);

    // Run 3: no match, gaps in cand_valid
    do_start(T, 1'b0);
    for (int i = 0; i < 10; i++) begin
      beat(mk(10 + i), i == 9);
      if (i % 3 == 1) tick();
    end
    tick();
    chk("r3_n_mv", n_mv_a, 0);
    chk("r3_found", found_a, 0);
    chk("r3_count", count_a, 10);
    chk("r3_n_done", n_done_a, 1);

    // Single-beat table: full-width (a) vs 32-bit truncated (b) compare
    for (int v = 0; v < 7; v++) begin
      do_start(vecs[v].tgt, 1'b0);
      beat(vecs[v].h, 1'b1);
      chk($sformatf("tbl%0d_mv_full", v), match_valid_a, vecs[v].hit_a);
      chk($sformatf("tbl%0d_mv_trunc", v), match_valid_b, vecs[v].hit_b);
      chk($sformatf("tbl%0d_done", v), done_a, 1);
      chk($sformatf("tbl%0d_count", v), count_a, 1);
      chk($sformatf("tbl%0d_found_trunc", v), found_b, vecs[v].hit_b);
      tick();
    end

    // Run 5: start during RUN ignored, abort beats a valid candidate
    do_start(T, 1'b0);
    beat(mk(0), 1'b0);
    beat(T, 1'b0);
    start = 1'b1; target = T2; first_only = 1'b1;
    beat(T2, 1'b0);
    start = 1'b0;
    chk("r5_busy", busy_a, 1);
    cand_valid = 1'b1; cand_hash = T; abort = 1'b1;
    #1;
    chk("r5_ready_abort", cand_ready_a, 0);
    tick();
    abort = 1'b0; cand_valid = 1'b0;
    chk("r5_done", done_a, 1);
    chk("r5_count_done", count_a, 3);
    tick();
    chk("r5_count_held", count_a, 3);
    chk("r5_found", found_a, 1);
    chk("r5_idx", match_idx_a, 1);
    chk("r5_mcnt", match_cnt_a, 1);
    chk("r5_n_mv", n_mv_a, 1);
    chk("r5_n_done", n_done_a, 1);
    chk("r5_busy_idle", busy_a, 0);

    // Run 6: 3-bit index overflow on dut_c, then reset dut_a mid-run
    do_start(T, 1'b0);
    for (int i = 0; i < 8; i++) beat(mk(30 + i), 1'b0);
    chk("r6_ovf_done", done_c, 1);
    chk("r6_ovf", ovf_c, 1);
    chk("r6_ovf_count", count_c, 0);
    chk("r6_wide_busy", busy_a, 1);
    chk("r6_wide_count", count_a, 8);
    chk("r6_wide_ovf", ovf_a, 0);
    cand_valid = 1'b1; cand_hash = T;
    #2;
    rst_n = 1'b0;
    #1;
    chk("r6_rst_ready", cand_ready_a, 0);
    chk("r6_rst_busy", busy_a, 0);
    chk("r6_rst_count", count_a, 0);
    chk("r6_rst_mv", match_valid_a, 0);
    chk("r6_rst_found", found_a, 0);
    chk("r6_rst_mcnt", match_cnt_a, 0);
    chk("r6_rst_ovf_c", ovf_c, 0);
    tick();
    chk("r6_rst_hold_count", count_a, 0);
    rst_n = 1'b1;
    cand_valid = 1'b0;
    tick();
    chk("r6_idle_ready", cand_ready_a, 0);
    chk("r6_idle_busy", busy_a, 0);
    do_start(T, 1'b0);
    beat(T, 1'b1);
    chk("r6_post_mv", match_valid_a, 1);
    chk("r6_post_idx", match_idx_a, 0);
    tick();
    chk("r6_post_found", found_a, 1);
    chk("r6_post_n_done", n_done_a, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
